// File: rtl/noc_port_allocator.sv
// Round-robin, packet-locked allocation of virtual channels and of the physical port for one router output.
// Optional macro NOC_PORT_ALLOCATOR_VC_PRIORITY_EN: port goes to the highest channel with an eligible requester.
module noc_port_allocator #(
    parameter int REQUESTERS = 5,
    parameter int CHANNELS   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQUESTERS*CHANNELS-1:0] vc_request,
    input  logic [REQUESTERS*CHANNELS-1:0] vc_free,
    output logic [REQUESTERS*CHANNELS-1:0] vc_grant,
    input  logic [REQUESTERS*CHANNELS-1:0] port_request,
    input  logic [REQUESTERS*CHANNELS-1:0] port_free,
    output logic [REQUESTERS*CHANNELS-1:0] port_grant
);
    localparam int N  = REQUESTERS * CHANNELS;
    localparam int RW = $clog2(REQUESTERS);
    localparam int NW = $clog2(N);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    // First requester strictly after 'last' (wrapping), returned as {found, index}.
    function automatic logic [RW:0] rr_pick_req(input logic [REQUESTERS-1:0] req,
                                                input logic [RW-1:0]         last);
        logic          found;
        logic          hit;
        logic [RW-1:0] idx;
        logic [RW-1:0] c_idx;
        int            cand;
        found = 1'b0;
        idx   = last;
        for (int k = 1; k <= REQUESTERS; k++) begin
            cand  = (int'(last) + k >= REQUESTERS) ? int'(last) + k - REQUESTERS : int'(last) + k;
            c_idx = RW'(cand);
            hit   = !found && req[c_idx];
            idx   = hit ? c_idx : idx;
            found = found | hit;
        end
        return {found, idx};
    endfunction

`ifndef NOC_PORT_ALLOCATOR_VC_PRIORITY_EN
    // First flattened candidate strictly after 'last' (wrapping), returned as {found, index}.
    function automatic logic [NW:0] rr_pick_flat(input logic [N-1:0]  req,
                                                 input logic [NW-1:0] last);
        logic          found;
        logic          hit;
        logic [NW-1:0] idx;
        logic [NW-1:0] c_idx;
        int            cand;
        found = 1'b0;
        idx   = last;
        for (int k = 1; k <= N; k++) begin
            cand  = (int'(last) + k >= N) ? int'(last) + k - N : int'(last) + k;
            c_idx = NW'(cand);
            hit   = !found && req[c_idx];
            idx   = hit ? c_idx : idx;
            found = found | hit;
        end
        return {found, idx};
    endfunction
`endif

    // ---------------- VC allocators ----------------
    state_t                r_vc_state     [CHANNELS];
    state_t                w_vc_state_nxt [CHANNELS];
    logic [RW-1:0]         r_vc_owner     [CHANNELS];
    logic [RW-1:0]         w_vc_owner_nxt [CHANNELS];
    logic [RW-1:0]         r_vc_ptr       [CHANNELS];
    logic [RW-1:0]         w_vc_ptr_nxt   [CHANNELS];
    logic [REQUESTERS-1:0] w_vc_req_ch    [CHANNELS];
    logic [REQUESTERS-1:0] w_vc_free_ch   [CHANNELS];
    logic [RW:0]           w_vc_pick      [CHANNELS];
    logic [N-1:0]          r_vc_grant;
    logic [N-1:0]          w_vc_grant_nxt;

    // Regroup the flattened request/free vectors by channel.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < REQUESTERS; r++) begin
                w_vc_req_ch[c][r]  = vc_request[r*CHANNELS+c];
                w_vc_free_ch[c][r] = vc_free[r*CHANNELS+c];
            end
        end
    end

    // Per-channel IDLE/BUSY next state and the grant vector it implies.
    always_comb begin
        w_vc_state_nxt = r_vc_state;
        w_vc_owner_nxt = r_vc_owner;
        w_vc_ptr_nxt   = r_vc_ptr;
        for (int c = 0; c < CHANNELS; c++) begin
            w_vc_pick[c] = rr_pick_req(w_vc_req_ch[c], r_vc_ptr[c]);
            case (r_vc_state[c])
                ST_IDLE: begin
                    if (w_vc_pick[c][RW]) begin
                        w_vc_state_nxt[c] = ST_BUSY;
                        w_vc_owner_nxt[c] = w_vc_pick[c][RW-1:0];
                        w_vc_ptr_nxt[c]   = w_vc_pick[c][RW-1:0];
                    end else begin
                        w_vc_state_nxt[c] = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (w_vc_free_ch[c][r_vc_owner[c]]) begin
                        w_vc_state_nxt[c] = ST_IDLE;
                    end else begin
                        w_vc_state_nxt[c] = ST_BUSY;
                    end
                end
                default: w_vc_state_nxt[c] = ST_IDLE;
            endcase
        end
        for (int r = 0; r < REQUESTERS; r++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                w_vc_grant_nxt[r*CHANNELS+c] = (w_vc_state_nxt[c] == ST_BUSY) &&
                                               (w_vc_owner_nxt[c] == RW'(r));
            end
        end
    end

    // VC allocator state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_vc_state[c] <= ST_IDLE;
                r_vc_owner[c] <= {RW{1'b0}};
                r_vc_ptr[c]   <= RW'(REQUESTERS - 1);
            end
            r_vc_grant <= {N{1'b0}};
        end else begin
            r_vc_state <= w_vc_state_nxt;
            r_vc_owner <= w_vc_owner_nxt;
            r_vc_ptr   <= w_vc_ptr_nxt;
            r_vc_grant <= w_vc_grant_nxt;
        end
    end

    // ---------------- Port allocator ----------------
    state_t        r_port_state;
    state_t        w_port_state_nxt;
    logic [NW-1:0] r_port_owner;
    logic [NW-1:0] w_port_owner_nxt;
    logic [N-1:0]  r_port_grant;
    logic [N-1:0]  w_port_grant_nxt;
    logic [N-1:0]  w_elig;
    logic          w_sel_found;
    logic [NW-1:0] w_sel_idx;

    // Only requesters that already own the channel may compete for the port.
    assign w_elig = port_request & r_vc_grant;

`ifdef NOC_PORT_ALLOCATOR_VC_PRIORITY_EN
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [RW-1:0]         r_port_ch_ptr     [CHANNELS];
    logic [RW-1:0]         w_port_ch_ptr_nxt [CHANNELS];
    logic [REQUESTERS-1:0] w_elig_ch         [CHANNELS];
    logic [CW-1:0]         w_sel_ch;
    logic [RW:0]           w_sel_pick;

    // Highest channel with any eligible requester, then round-robin inside it.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_ch    = {CW{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < REQUESTERS; r++) begin
                w_elig_ch[c][r] = w_elig[r*CHANNELS+c];
            end
            w_sel_ch    = (|w_elig_ch[c]) ? CW'(c) : w_sel_ch;
            w_sel_found = w_sel_found | (|w_elig_ch[c]);
        end
        w_sel_pick = rr_pick_req(w_elig_ch[w_sel_ch], r_port_ch_ptr[w_sel_ch]);
        w_sel_idx  = NW'(int'(w_sel_pick[RW-1:0]) * CHANNELS + int'(w_sel_ch));
    end
`else
    logic [NW-1:0] r_port_ptr;
    logic [NW-1:0] w_port_ptr_nxt;
    logic [NW:0]   w_sel_pick;

    // Flat round-robin over every (requester, channel) candidate.
    always_comb begin
        w_sel_pick  = rr_pick_flat(w_elig, r_port_ptr);
        w_sel_found = w_sel_pick[NW];
        w_sel_idx   = w_sel_pick[NW-1:0];
    end
`endif

    // Port IDLE/BUSY next state, pointer advance and one-hot grant.
    always_comb begin
        w_port_state_nxt = r_port_state;
        w_port_owner_nxt = r_port_owner;
`ifdef NOC_PORT_ALLOCATOR_VC_PRIORITY_EN
        w_port_ch_ptr_nxt = r_port_ch_ptr;
`else
        w_port_ptr_nxt = r_port_ptr;
`endif
        case (r_port_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_port_state_nxt = ST_BUSY;
                    w_port_owner_nxt = w_sel_idx;
`ifdef NOC_PORT_ALLOCATOR_VC_PRIORITY_EN
                    w_port_ch_ptr_nxt[w_sel_ch] = w_sel_pick[RW-1:0];
`else
                    w_port_ptr_nxt = w_sel_idx;
`endif
                end else begin
                    w_port_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (port_free[r_port_owner]) begin
                    w_port_state_nxt = ST_IDLE;
                end else begin
                    w_port_state_nxt = ST_BUSY;
                end
            end
            default: w_port_state_nxt = ST_IDLE;
        endcase
        for (int i = 0; i < N; i++) begin
            w_port_grant_nxt[i] = (w_port_state_nxt == ST_BUSY) && (w_port_owner_nxt == NW'(i));
        end
    end

    // Port allocator state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port_state <= ST_IDLE;
            r_port_owner <= {NW{1'b0}};
            r_port_grant <= {N{1'b0}};
`ifdef NOC_PORT_ALLOCATOR_VC_PRIORITY_EN
            for (int c = 0; c < CHANNELS; c++) begin
                r_port_ch_ptr[c] <= RW'(REQUESTERS - 1);
            end
`else
            r_port_ptr <= NW'(N - 1);
`endif
        end else begin
            r_port_state <= w_port_state_nxt;
            r_port_owner <= w_port_owner_nxt;
            r_port_grant <= w_port_grant_nxt;
`ifdef NOC_PORT_ALLOCATOR_VC_PRIORITY_EN
            r_port_ch_ptr <= w_port_ch_ptr_nxt;
`else
            r_port_ptr <= w_port_ptr_nxt;
`endif
        end
    end

    assign vc_grant   = r_vc_grant;
    assign port_grant = r_port_grant;

endmodule

// File: tb/tb_noc_port_allocator.sv
// Table-driven bench for noc_port_allocator (5 requesters x 2 channels) with a one-cycle-latency scoreboard.
module tb_noc_port_allocator;
    localparam int N = 10;

`ifdef NOC_PORT_ALLOCATOR_VC_PRIORITY_EN
    localparam logic [N-1:0] EXP_BOTH = 10'h200;
`else
    localparam logic [N-1:0] EXP_BOTH = 10'h001;
`endif

    typedef struct {
        logic         rst;
        logic [N-1:0] vc_req;
        logic [N-1:0] vc_fr;
        logic [N-1:0] p_req;
        logic [N-1:0] p_fr;
        logic [N-1:0] exp_vc;
        logic [N-1:0] exp_port;
    } vec_t;

    typedef struct {
        logic [N-1:0] exp_vc;
        logic [N-1:0] exp_port;
        int           idx;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] vc_request   = '0;
    logic [N-1:0] vc_free      = '0;
    logic [N-1:0] port_request = '0;
    logic [N-1:0] port_free    = '0;
    logic [N-1:0] vc_grant;
    logic [N-1:0] port_grant;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    noc_port_allocator #(.REQUESTERS(5), .CHANNELS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .vc_request   (vc_request),
        .vc_free      (vc_free),
        .vc_grant     (vc_grant),
        .port_request (port_request),
        .port_free    (port_free),
        .port_grant   (port_grant)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [N-1:0] vq, input logic [N-1:0] vf,
                       input logic [N-1:0] pq, input logic [N-1:0] pf,
                       input logic [N-1:0] ev, input logic [N-1:0] ep);
        vec_t v;
        v.rst = r; v.vc_req = vq; v.vc_fr = vf; v.p_req = pq; v.p_fr = pf;
        v.exp_vc = ev; v.exp_port = ep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] vq, input logic [N-1:0] vf,
                         input logic [N-1:0] pq, input logic [N-1:0] pf);
        rst = r; vc_request = vq; vc_free = vf; port_request = pq; port_free = pf;
    endtask

    initial begin
        sb_t e;
        int  cyc;
        int  vc_seen;

        //    rst   vc_req   vc_free  p_req    p_free   exp_vc   exp_port
        add(1'b1, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000); // reset
        add(1'b0, 10'h041, 10'h000, 10'h000, 10'h000, 10'h001, 10'h000); // r0,r3 on c0 -> r0
        add(1'b0, 10'h041, 10'h001, 10'h000, 10'h000, 10'h000, 10'h000); // free -> bubble
        add(1'b0, 10'h041, 10'h000, 10'h000, 10'h000, 10'h040, 10'h000); // r3 next
        add(1'b0, 10'h000, 10'h040, 10'h000, 10'h000, 10'h000, 10'h000);
        add(1'b0, 10'h028, 10'h000, 10'h000, 10'h000, 10'h008, 10'h000); // r1,r2 on c1 -> r1
        add(1'b0, 10'h000, 10'h020, 10'h000, 10'h000, 10'h008, 10'h000); // non-owner free ignored
        add(1'b0, 10'h000, 10'h008, 10'h000, 10'h000, 10'h000, 10'h000);
        add(1'b0, 10'h004, 10'h000, 10'h000, 10'h000, 10'h004, 10'h000); // r1 owns c0
        add(1'b0, 10'h000, 10'h000, 10'h004, 10'h000, 10'h004, 10'h004); // port granted
        add(1'b0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h004, 10'h004); // request dropped, held
        add(1'b0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h004, 10'h004);
        add(1'b0, 10'h000, 10'h000, 10'h000, 10'h004, 10'h004, 10'h000); // port_free
        add(1'b0, 10'h000, 10'h004, 10'h000, 10'h000, 10'h000, 10'h000);
        add(1'b0, 10'h000, 10'h000, 10'h010, 10'h000, 10'h000, 10'h000); // no ownership
        add(1'b0, 10'h000, 10'h000, 10'h010, 10'h000, 10'h000, 10'h000);
        add(1'b0, 10'h010, 10'h000, 10'h010, 10'h000, 10'h010, 10'h000); // vc at t+1
        add(1'b0, 10'h000, 10'h000, 10'h010, 10'h000, 10'h010, 10'h010); // port at t+2
        add(1'b0, 10'h000, 10'h010, 10'h000, 10'h010, 10'h000, 10'h000); // both frees together
        add(1'b1, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000); // reset
        add(1'b0, 10'h201, 10'h000, 10'h000, 10'h000, 10'h201, 10'h000); // (r0,c0),(r4,c1)
        add(1'b0, 10'h201, 10'h000, 10'h201, 10'h000, 10'h201, EXP_BOTH);
        add(1'b0, 10'h000, 10'h201, 10'h000, 10'h201, 10'h000, 10'h000);
        add(1'b0, 10'h002, 10'h000, 10'h000, 10'h000, 10'h002, 10'h000); // r0 owns c1
        add(1'b0, 10'h000, 10'h000, 10'h002, 10'h000, 10'h002, 10'h002);
        add(1'b1, 10'h002, 10'h000, 10'h002, 10'h000, 10'h000, 10'h000); // reset mid-packet
        add(1'b0, 10'h011, 10'h000, 10'h000, 10'h000, 10'h001, 10'h000); // r0,r2 -> r0 after reset
        add(1'b0, 10'h011, 10'h000, 10'h011, 10'h000, 10'h001, 10'h001);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].vc_req, vecs[i].vc_fr, vecs[i].p_req, vecs[i].p_fr);
            sb.push_back('{exp_vc: vecs[i].exp_vc, exp_port: vecs[i].exp_port, idx: i});
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("v%0d vc_grant", e.idx), vc_grant, e.exp_vc);
            chk($sformatf("v%0d port_grant", e.idx), port_grant, e.exp_port);
        end

        // Port request without channel ownership never wins, however long it is held.
        drive(1'b1, '0, '0, '0, '0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, '0, 10'h080, '0);
            @(posedge clk); #1;
            chk($sformatf("orphan port_req cyc%0d", i), port_grant, 10'h000);
        end

        // Bounded wait: grant latency from vc_request on (r3,c1) with port already requested.
        drive(1'b0, 10'h080, '0, 10'h080, '0);
        cyc     = 0;
        vc_seen = 0;
        while (cyc < 8 && port_grant[7] !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
            if (vc_grant[7] === 1'b1 && vc_seen == 0) vc_seen = cyc;
            vc_request = '0;
        end
        chk("vc latency", 10'(vc_seen), 10'd1);
        chk("port latency", 10'(cyc), 10'd2);
        chk("port one-hot", port_grant, 10'h080);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
